// File: rtl/control_unit.sv
// Multi-cycle LEGv8-subset control unit: FETCH/EXEC/LOAD2/HALT sequencer driving the datapath
// control word and immediate. Define BRANCH_LINK_EN to execute BL; otherwise BL halts.
module control_unit #(
  parameter logic [4:0] LINK_REG = 5'd30
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic [4:0]  status,
  output logic [30:0] controlword,
  output logic [63:0] immediate,
  output logic [1:0]  state,
  output logic        halted
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    LOAD2 = 2'd2,
    HALT  = 2'd3
  } state_t;

  typedef enum logic [3:0] {
    OP_UNDEF, OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_EOR, OP_SUBS, OP_ADDI,
    OP_SUBI, OP_STUR, OP_LDUR, OP_B, OP_BL, OP_CBZ, OP_CBNZ, OP_BCOND
  } op_t;

  typedef struct packed {
    logic       bus_alu_en;
    logic       alu_b_sel;
    logic [4:0] alu_fs;
    logic       bus_rfb_en;
    logic [4:0] sa;
    logic [4:0] sb;
    logic [4:0] da;
    logic       rf_write;
    logic       bus_ram_en;
    logic       ram_write;
    logic       bus_pc_en;
    logic [1:0] pc_fs;
    logic       pc_in_sel;
    logic       status_load;
  } ctrl_t;

  localparam logic [4:0] ALU_AND = 5'b00000;
  localparam logic [4:0] ALU_OR  = 5'b00100;
  localparam logic [4:0] ALU_XOR = 5'b01100;
  localparam logic [4:0] ALU_ADD = 5'b01000;
  localparam logic [4:0] ALU_SUB = 5'b01011;

  localparam logic [1:0] PC_HOLD = 2'b00;
  localparam logic [1:0] PC_INC  = 2'b01;
  localparam logic [1:0] PC_REL  = 2'b11;

  localparam logic [4:0] XZR = 5'd31;

  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [10:0] OPC_EOR  = 11'b11001010000;
  localparam logic [10:0] OPC_SUBS = 11'b11101011000;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
  localparam logic [9:0]  OPC_SUBI = 10'b1101000100;
  localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
  localparam logic [7:0]  OPC_CBNZ = 8'b10110101;
  localparam logic [7:0]  OPC_BCND = 8'b01010100;
  localparam logic [5:0]  OPC_B    = 6'b000101;
  localparam logic [5:0]  OPC_BL   = 6'b100101;

`ifdef BRANCH_LINK_EN
  localparam logic BL_ENABLED = 1'b1;
`else
  localparam logic BL_ENABLED = 1'b0;
`endif

  state_t      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic        halted_q, halted_d;

  logic [10:0] op11;
  logic [9:0]  op10;
  logic [7:0]  op8;
  logic [5:0]  op6;
  logic [4:0]  rd, rn, rm;
  logic [3:0]  cond;

  assign op11 = ir_q[31:21];
  assign op10 = ir_q[31:22];
  assign op8  = ir_q[31:24];
  assign op6  = ir_q[31:26];
  assign rd   = ir_q[4:0];
  assign rn   = ir_q[9:5];
  assign rm   = ir_q[20:16];
  assign cond = ir_q[3:0];

  logic [63:0] imm_alu12, imm_dt9, imm_cb19, imm_br26;

  assign imm_alu12 = {52'd0, ir_q[21:10]};
  assign imm_dt9   = {{55{ir_q[20]}}, ir_q[20:12]};
  assign imm_cb19  = {{45{ir_q[23]}}, ir_q[23:5]};
  assign imm_br26  = {{38{ir_q[25]}}, ir_q[25:0]};

  logic z_live, z_reg, n_reg, c_reg_unused, v_reg;

  assign z_live       = status[0];
  assign z_reg        = status[1];
  assign n_reg        = status[2];
  assign c_reg_unused = status[3];
  assign v_reg        = status[4];

  op_t op;

  // Shortest opcodes are matched first so that longer matches overwrite them.
  always_comb begin
    op = OP_UNDEF;
    if (op6 == OPC_B) op = OP_B;
    if (BL_ENABLED && (op6 == OPC_BL)) op = OP_BL;
    case (op8)
      OPC_CBZ:  op = OP_CBZ;
      OPC_CBNZ: op = OP_CBNZ;
      OPC_BCND: op = OP_BCOND;
      default:  ;
    endcase
    case (op10)
      OPC_ADDI: op = OP_ADDI;
      OPC_SUBI: op = OP_SUBI;
      default:  ;
    endcase
    case (op11)
      OPC_ADD:  op = OP_ADD;
      OPC_SUB:  op = OP_SUB;
      OPC_AND:  op = OP_AND;
      OPC_ORR:  op = OP_ORR;
      OPC_EOR:  op = OP_EOR;
      OPC_SUBS: op = OP_SUBS;
      OPC_STUR: op = OP_STUR;
      OPC_LDUR: op = OP_LDUR;
      default:  ;
    endcase
  end

  logic [4:0] arith_fs;

  always_comb begin
    case (op)
      OP_SUB, OP_SUBS, OP_SUBI: arith_fs = ALU_SUB;
      OP_AND:                   arith_fs = ALU_AND;
      OP_ORR:                   arith_fs = ALU_OR;
      OP_EOR:                   arith_fs = ALU_XOR;
      default:                  arith_fs = ALU_ADD;
    endcase
  end

  logic cond_valid, cond_taken, cb_taken;

  always_comb begin
    cond_valid = 1'b1;
    cond_taken = 1'b0;
    case (cond)
      4'b0000: cond_taken = z_reg;
      4'b0001: cond_taken = ~z_reg;
      4'b1010: cond_taken = (n_reg == v_reg);
      4'b1011: cond_taken = (n_reg != v_reg);
      default: cond_valid = 1'b0;
    endcase
  end

  // CBZ/CBNZ pass Rt through the ALU as XZR|Rt, so the live Z reflects Rt==0.
  assign cb_taken = (op == OP_CBZ) ? z_live : ~z_live;

  ctrl_t       exec_ctrl;
  logic [63:0] exec_imm;
  state_t      exec_next;

  always_comb begin
    exec_ctrl = '0;
    exec_imm  = '0;
    exec_next = FETCH;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_EOR, OP_SUBS, OP_ADDI, OP_SUBI: begin
        exec_ctrl.bus_alu_en  = 1'b1;
        exec_ctrl.alu_fs      = arith_fs;
        exec_ctrl.sa          = rn;
        exec_ctrl.sb          = rm;
        exec_ctrl.da          = rd;
        exec_ctrl.rf_write    = 1'b1;
        exec_ctrl.pc_fs       = PC_INC;
        exec_ctrl.status_load = (op == OP_SUBS);
        if ((op == OP_ADDI) || (op == OP_SUBI)) begin
          exec_ctrl.alu_b_sel = 1'b1;
          exec_imm            = imm_alu12;
        end
      end
      OP_STUR, OP_LDUR: begin
        exec_ctrl.alu_b_sel = 1'b1;
        exec_ctrl.alu_fs    = ALU_ADD;
        exec_ctrl.sa        = rn;
        exec_ctrl.sb        = rd;
        exec_imm            = imm_dt9;
        if (op == OP_STUR) begin
          exec_ctrl.bus_rfb_en = 1'b1;
          exec_ctrl.ram_write  = 1'b1;
          exec_ctrl.pc_fs      = PC_INC;
        end else begin
          exec_ctrl.bus_ram_en = 1'b1;
          exec_ctrl.pc_fs      = PC_HOLD;
          exec_next            = LOAD2;
        end
      end
      OP_B: begin
        exec_ctrl.pc_in_sel = 1'b1;
        exec_ctrl.pc_fs     = PC_REL;
        exec_imm            = imm_br26;
      end
      OP_BL: begin
        exec_ctrl.bus_pc_en = 1'b1;
        exec_ctrl.da        = LINK_REG;
        exec_ctrl.rf_write  = 1'b1;
        exec_ctrl.pc_in_sel = 1'b1;
        exec_ctrl.pc_fs     = PC_REL;
        exec_imm            = imm_br26;
      end
      OP_CBZ, OP_CBNZ: begin
        exec_ctrl.alu_fs    = ALU_OR;
        exec_ctrl.sa        = XZR;
        exec_ctrl.sb        = rd;
        exec_ctrl.pc_in_sel = cb_taken;
        exec_ctrl.pc_fs     = cb_taken ? PC_REL : PC_INC;
        exec_imm            = imm_cb19;
      end
      OP_BCOND: begin
        if (cond_valid) begin
          exec_ctrl.pc_in_sel = cond_taken;
          exec_ctrl.pc_fs     = cond_taken ? PC_REL : PC_INC;
          exec_imm            = imm_cb19;
        end else begin
          exec_next = HALT;
        end
      end
      default: exec_next = HALT;
    endcase
  end

  ctrl_t out_ctrl;

  always_comb begin
    out_ctrl  = '0;
    immediate = '0;
    case (state_q)
      EXEC: begin
        out_ctrl  = exec_ctrl;
        immediate = exec_imm;
      end
      LOAD2: begin
        out_ctrl          = exec_ctrl;
        out_ctrl.da       = rd;
        out_ctrl.rf_write = 1'b1;
        out_ctrl.pc_fs    = PC_INC;
        immediate         = exec_imm;
      end
      default: ;
    endcase
  end

  assign controlword = out_ctrl;

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      FETCH: begin
        ir_d    = instruction;
        state_d = EXEC;
      end
      EXEC:    state_d = exec_next;
      LOAD2:   state_d = FETCH;
      default: state_d = HALT;
    endcase
    halted_d = (state_d == HALT);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= FETCH;
      ir_q     <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      halted_q <= halted_d;
    end
  end

  assign state  = state_q;
  assign halted = halted_q;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: table-driven instruction model checked every cycle,
// plus hand-computed control words for the key instructions.
module tb_control_unit;

  logic        clock;
  logic        reset;
  logic [31:0] instruction;
  logic [4:0]  status;
  logic [30:0] controlword;
  logic [63:0] immediate;
  logic [1:0]  state;
  logic        halted;

  control_unit #(.LINK_REG(5'd30)) dut (
    .clock       (clock),
    .reset       (reset),
    .instruction (instruction),
    .status      (status),
    .controlword (controlword),
    .immediate   (immediate),
    .state       (state),
    .halted      (halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

`ifdef BRANCH_LINK_EN
  localparam bit BL_EN = 1'b1;
`else
  localparam bit BL_EN = 1'b0;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Opcode table, indexed by instruction kind.
  localparam int K_ADD = 0, K_SUB = 1, K_AND = 2, K_ORR = 3, K_EOR = 4, K_SUBS = 5;
  localparam int K_ADDI = 6, K_SUBI = 7, K_STUR = 8, K_LDUR = 9, K_B = 10;
  localparam int K_CBZ = 11, K_CBNZ = 12, K_BCOND = 13, K_BL = 14, K_UNDEF = 15;
  int op_val [15] = '{'h458, 'h658, 'h450, 'h550, 'h650, 'h758, 'h244, 'h344,
                      'h7C0, 'h7C2, 'h05, 'hB4, 'hB5, 'h54, 'h25};
  int op_len [15] = '{11, 11, 11, 11, 11, 11, 10, 10, 11, 11, 6, 8, 8, 8, 6};

  function automatic int classify(input logic [31:0] ir);
    int best = K_UNDEF;
    int best_len = 0;
    for (int i = 0; i < 15; i++) begin
      if (i == K_BL && !BL_EN) continue;
      if (int'(ir >> (32 - op_len[i])) == op_val[i] && op_len[i] > best_len) begin
        best = i;
        best_len = op_len[i];
      end
    end
    return best;
  endfunction

  function automatic logic [63:0] sext(input int v, input int bits);
    logic [63:0] u = 64'(v);
    if (((v >> (bits - 1)) & 1) == 1) u = u - (64'd1 << bits);
    return u;
  endfunction

  // Expected outputs for an EXEC (load2=0) or LOAD2 (load2=1) cycle; nxt is the state after EXEC.
  task automatic model_exec(input logic [31:0] ir, input logic [4:0] st, input bit load2,
                            output logic [30:0] cw, output logic [63:0] imm, output int nxt);
    int k = classify(ir);
    int w = int'(ir);
    int rd = w & 31;
    int rn = (w >> 5) & 31;
    int rm = (w >> 16) & 31;
    int alu_en = 0, bsel = 0, fs = 0, rfb = 0, sa = 0, sb = 0, da = 0, rfw = 0;
    int ram = 0, ramw = 0, pcen = 0, pcfs = 0, insel = 0, sl = 0;
    int taken = 0;
    int c;
    imm = '0;
    nxt = 0;
    if (k <= K_SUBI) begin
      alu_en = 1; sa = rn; sb = rm; da = rd; rfw = 1; pcfs = 1;
      if (k == K_ADD || k == K_ADDI) fs = 8;
      else if (k == K_AND) fs = 0;
      else if (k == K_ORR) fs = 4;
      else if (k == K_EOR) fs = 12;
      else fs = 11;
      sl = (k == K_SUBS) ? 1 : 0;
      if (k == K_ADDI || k == K_SUBI) begin
        bsel = 1;
        imm = 64'((w >> 10) & 'hFFF);
      end
    end else if (k == K_STUR || k == K_LDUR) begin
      bsel = 1; fs = 8; sa = rn; sb = rd;
      imm = sext((w >> 12) & 'h1FF, 9);
      if (k == K_STUR) begin
        rfb = 1; ramw = 1; pcfs = 1;
      end else begin
        ram = 1;
        if (load2) begin da = rd; rfw = 1; pcfs = 1; end
        else nxt = 2;
      end
    end else if (k == K_B || k == K_BL) begin
      imm = sext(w & 'h3FFFFFF, 26); insel = 1; pcfs = 3;
      if (k == K_BL) begin pcen = 1; da = 30; rfw = 1; end
    end else if (k == K_CBZ || k == K_CBNZ) begin
      imm = sext((w >> 5) & 'h7FFFF, 19);
      sa = 31; sb = rd; fs = 4;
      taken = ((k == K_CBZ) == (st[0] == 1'b1)) ? 1 : 0;
      pcfs = taken ? 3 : 1; insel = taken;
    end else if (k == K_BCOND) begin
      c = w & 15;
      if (c == 0) taken = st[1];
      else if (c == 1) taken = !st[1];
      else if (c == 10) taken = (st[2] == st[4]) ? 1 : 0;
      else if (c == 11) taken = (st[2] != st[4]) ? 1 : 0;
      else nxt = 3;
      if (nxt != 3) begin
        imm = sext((w >> 5) & 'h7FFFF, 19);
        pcfs = taken ? 3 : 1; insel = taken;
      end
    end else begin
      nxt = 3;
    end
    cw = 31'(alu_en * (1 << 30) + bsel * (1 << 29) + fs * (1 << 24) + rfb * (1 << 23)
             + sa * (1 << 18) + sb * (1 << 13) + da * (1 << 8) + rfw * 128 + ram * 64
             + ramw * 32 + pcen * 16 + pcfs * 4 + insel * 2 + sl);
  endtask

  int          m_state = 0;
  logic [31:0] m_ir = '0;

  always @(posedge clock or posedge reset) begin
    logic [30:0] cw_t;
    logic [63:0] imm_t;
    int nx;
    if (reset) begin
      m_state = 0;
      m_ir = '0;
    end else begin
      case (m_state)
        0: begin m_ir = instruction; m_state = 1; end
        1: begin model_exec(m_ir, status, 1'b0, cw_t, imm_t, nx); m_state = nx; end
        2: m_state = 0;
        default: m_state = 3;
      endcase
    end
  end

  always @(negedge clock) begin
    logic [30:0] e_cw;
    logic [63:0] e_imm;
    int nx;
    e_cw = '0;
    e_imm = '0;
    if (m_state == 1) model_exec(m_ir, status, 1'b0, e_cw, e_imm, nx);
    else if (m_state == 2) model_exec(m_ir, status, 1'b1, e_cw, e_imm, nx);
    check("cmp state", 64'(state), 64'(m_state));
    check("cmp controlword", 64'(controlword), 64'(e_cw));
    check("cmp immediate", immediate, e_imm);
    check("cmp halted", 64'(halted), 64'(m_state == 3));
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic to_fetch();
    int n = 0;
    do begin
      step();
      n++;
    end while (state !== 2'd0 && n < 8);
    check("reach fetch", 64'(state === 2'd0), 64'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("reset state", 64'(state), 64'd0);
    check("reset halted", 64'(halted), 64'd0);
  endtask

  // Called in FETCH; leaves the bench in the EXEC cycle of the issued instruction.
  task automatic exec_issue(input string name, input logic [31:0] instr, input logic [4:0] st,
                            input logic [30:0] exp_cw, input logic [63:0] exp_imm);
    instruction = instr;
    status = st;
    step();
    check({name, " state"}, 64'(state), 64'd1);
    check({name, " cw"}, 64'(controlword), 64'(exp_cw));
    check({name, " imm"}, immediate, exp_imm);
  endtask

  logic [31:0] vec_ir [16] = '{
    32'h8B0700C5, 32'hCB0700C5, 32'h8A0700C5, 32'hAA0700C5, 32'hCA0700C5, 32'hD13FFD49,
    32'h17FFFFFF, 32'h54000041, 32'h54000041, 32'h5400004A, 32'h5400004A, 32'h5400004B,
    32'h5400004B, 32'hB5000064, 32'hB5000064, 32'h54FFFFC0};
  logic [4:0] vec_st [16] = '{
    5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000,
    5'b00000, 5'b00000, 5'b00010, 5'b10100, 5'b00100, 5'b00100,
    5'b00000, 5'b00000, 5'b00001, 5'b00001};

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    instruction = '0;
    status = '0;
    #2 reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst state", 64'(state), 64'd0);
    check("rst cw", 64'(controlword), 64'd0);
    check("rst imm", immediate, 64'd0);
    check("rst halted", 64'(halted), 64'd0);
    reset = 1'b0;

    exec_issue("addi", 32'h91001401, 5'b00000, 31'h68000184, 64'd5);
    to_fetch();

    exec_issue("ldur", 32'hF85F8022, 5'b00000, 31'h28044040, 64'hFFFF_FFFF_FFFF_FFF8);
    step();
    check("ldur2 state", 64'(state), 64'd2);
    check("ldur2 cw", 64'(controlword), 64'h280442C4);
    check("ldur2 imm", immediate, 64'hFFFF_FFFF_FFFF_FFF8);
    step();
    check("ldur done", 64'(state), 64'd0);

    exec_issue("subs", 32'hEB010023, 5'b00000, 31'h4B042385, 64'd0);
    to_fetch();
    exec_issue("beq taken", 32'h54FFFFC0, 5'b00011, 31'h0000000E, 64'hFFFF_FFFF_FFFF_FFFE);
    to_fetch();
    exec_issue("beq not", 32'h54FFFFC0, 5'b00000, 31'h00000004, 64'hFFFF_FFFF_FFFF_FFFE);
    to_fetch();
    exec_issue("cbz taken", 32'hB4000064, 5'b00001, 31'h047C800E, 64'd3);
    to_fetch();
    exec_issue("cbz not", 32'hB4000064, 5'b00000, 31'h047C8004, 64'd3);
    to_fetch();
    exec_issue("stur", 32'hF80100C5, 5'b00000, 31'h2898A024, 64'd16);
    to_fetch();

    for (int i = 0; i < 16; i++) begin
      instruction = vec_ir[i];
      status = vec_st[i];
      step();
      to_fetch();
    end

    // Reset during the second LDUR cycle.
    instruction = 32'hF85F8022;
    status = '0;
    step();
    step();
    reset = 1'b1;
    #1;
    check("abort state", 64'(state), 64'd0);
    check("abort cw", 64'(controlword), 64'd0);
    check("abort imm", immediate, 64'd0);
    step();
    reset = 1'b0;

    exec_issue("undef", 32'hFFFFFFFF, 5'b00000, 31'h0, 64'd0);
    step();
    for (int i = 0; i < 10; i++) begin
      check("halt state", 64'(state), 64'd3);
      check("halt flag", 64'(halted), 64'd1);
      check("halt cw", 64'(controlword), 64'd0);
      step();
    end
    do_reset();

    exec_issue("bcond bad", 32'h54000022, 5'b00011, 31'h0, 64'd0);
    step();
    check("bcond bad halt", 64'(state), 64'd3);
    do_reset();

    if (BL_EN) begin
      exec_issue("bl", 32'h94000004, 5'b00000, 31'h00001E9E, 64'd4);
      to_fetch();
    end else begin
      exec_issue("bl undef", 32'h94000004, 5'b00000, 31'h0, 64'd0);
      step();
      check("bl halt", 64'(halted), 64'd1);
      do_reset();
    end

    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
